// File: rtl/peak_bin_detect.sv
// peak_bin_detect: scans a bin window of NCH FFT RAMs and reports the bin with the largest summed |re|+|im|.
module peak_bin_detect #(
  parameter int NCH = 4,
  parameter int NBINS = 1024,
  parameter int HW = 16,
  localparam int AW = $clog2(NBINS),
  localparam int MW = HW + 1 + $clog2(NCH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fftdone,
  input  logic [AW-1:0]         bin_lo,
  input  logic [AW-1:0]         bin_hi,
  input  logic [MW-1:0]         thresh,
  output logic [AW-1:0]         ramaddr,
  input  logic [NCH*2*HW-1:0]   ramq,
  output logic                  busy,
  output logic                  detectdone,
  output logic [AW-1:0]         maxbin,
  output logic [MW-1:0]         maxmag,
  output logic                  found
);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] lo_q, lo_d, hi_q, hi_d, addr_q, addr_d, db_q, db_d;
  logic [AW-1:0] run_bin_q, run_bin_d, maxbin_q, maxbin_d;
  logic [MW-1:0] th_q, th_d, run_mag_q, run_mag_d, maxmag_q, maxmag_d;
  logic empty_q, empty_d, dv_q, dv_d, dfirst_q, dfirst_d;
  logic busy_q, busy_d, done_q, done_d, found_q, found_d;
  logic [HW:0] mag [NCH];
  logic [MW-1:0] sum;
  // Magnitudes are formed at HW+1 bits so |-2^(HW-1)| is exact.
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic signed [HW:0] re, im;
    assign re = {ramq[k*2*HW+2*HW-1], ramq[k*2*HW+HW +: HW]};
    assign im = {ramq[k*2*HW+HW-1], ramq[k*2*HW +: HW]};
    assign mag[k] = (re[HW] ? -re : re) + (im[HW] ? -im : im);
  end
  always_comb begin
    sum = '0;
    for (int k = 0; k < NCH; k++) sum = sum + MW'(mag[k]);
  end
  always_comb begin
    state_d = state_q;
    lo_d = lo_q;
    hi_d = hi_q;
    th_d = th_q;
    empty_d = empty_q;
    addr_d = addr_q;
    maxbin_d = maxbin_q;
    maxmag_d = maxmag_q;
    found_d = found_q;
    done_d = 1'b0;
    run_bin_d = run_bin_q;
    run_mag_d = run_mag_q;
    // Read data lags the issued address by one cycle; dv/db/dfirst tag it.
    dv_d = state_q == SCAN;
    db_d = addr_q;
    dfirst_d = state_q == SCAN && addr_q == lo_q;
    if (dv_q && (dfirst_q || sum > run_mag_q)) begin
      run_mag_d = sum;
      run_bin_d = db_q;
    end
    case (state_q)
      IDLE: if (fftdone) begin
        lo_d = bin_lo;
        hi_d = bin_hi;
        th_d = thresh;
        empty_d = bin_lo > bin_hi;
        run_bin_d = bin_lo;
        run_mag_d = '0;
        state_d = bin_lo > bin_hi ? DONE : SCAN;
        addr_d = bin_lo > bin_hi ? addr_q : bin_lo;
      end
      SCAN: begin
        state_d = addr_q == hi_q ? DRAIN : SCAN;
        addr_d = addr_q == hi_q ? addr_q : addr_q + 1'b1;
      end
      DRAIN: state_d = DONE;
      DONE: begin
        state_d = IDLE;
        done_d = 1'b1;
        maxbin_d = run_bin_q;
        maxmag_d = run_mag_q;
        found_d = !empty_q && run_mag_q >= th_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      lo_q <= '0;
      hi_q <= '0;
      th_q <= '0;
      empty_q <= 1'b0;
      addr_q <= '0;
      db_q <= '0;
      dv_q <= 1'b0;
      dfirst_q <= 1'b0;
      run_bin_q <= '0;
      run_mag_q <= '0;
      maxbin_q <= '0;
      maxmag_q <= '0;
      found_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
      th_q <= th_d;
      empty_q <= empty_d;
      addr_q <= addr_d;
      db_q <= db_d;
      dv_q <= dv_d;
      dfirst_q <= dfirst_d;
      run_bin_q <= run_bin_d;
      run_mag_q <= run_mag_d;
      maxbin_q <= maxbin_d;
      maxmag_q <= maxmag_d;
      found_q <= found_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign ramaddr = addr_q;
  assign busy = busy_q;
  assign detectdone = done_q;
  assign maxbin = maxbin_q;
  assign maxmag = maxmag_q;
  assign found = found_q;
endmodule

// File: tb/tb_peak_bin_detect.sv
// tb_peak_bin_detect: directed scenarios against a behavioural 1-cycle-latency FFT RAM.
module tb_peak_bin_detect;
  localparam int NCH = 4, NBINS = 1024, HW = 16, AW = 10, MW = 19;
  logic clk = 1'b0, reset = 1'b1, fftdone = 1'b0;
  logic [AW-1:0] bin_lo = '0, bin_hi = '0, ramaddr, maxbin;
  logic [MW-1:0] thresh = '0, maxmag;
  logic [NCH*2*HW-1:0] ramq = '0;
  logic busy, detectdone, found;
  logic [NCH*2*HW-1:0] mem [NBINS];
  int checks = 0, fails = 0, lat, pulses;

  peak_bin_detect dut (
    .clk(clk), .reset(reset), .fftdone(fftdone), .bin_lo(bin_lo), .bin_hi(bin_hi),
    .thresh(thresh), .ramaddr(ramaddr), .ramq(ramq), .busy(busy),
    .detectdone(detectdone), .maxbin(maxbin), .maxmag(maxmag), .found(found)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ramq <= mem[ramaddr];

  task automatic clear_mem();
    foreach (mem[i]) mem[i] = '0;
  endtask

  task automatic set_ch(input int b, input int ch, input int re, input int im);
    mem[b][ch*2*HW +: 2*HW] = {16'(re), 16'(im)};
  endtask

  task automatic set_all(input int b, input int re, input int im);
    for (int c = 0; c < NCH; c++) set_ch(b, c, re, im);
  endtask

  // Leaves the bench at the falling edge just after the accepting edge E0.
  task automatic start(input int lo, input int hi, input int th);
    @(negedge clk);
    bin_lo = AW'(lo);
    bin_hi = AW'(hi);
    thresh = MW'(th);
    fftdone = 1'b1;
    @(negedge clk);
    fftdone = 1'b0;
    bin_lo = '1;
    bin_hi = '0;
    thresh = '0;
  endtask

  task automatic wait_done(input int budget);
    lat = -1;
    pulses = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (detectdone === 1'b1) begin
        pulses++;
        if (lat < 0) lat = k;
      end
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    @(negedge clk);
    checks++; if (ramaddr !== 10'd0) begin fails++; $display("FAIL reset ramaddr: got %0d expected 0", ramaddr); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %b expected 0", busy); end
    checks++; if (detectdone !== 1'b0) begin fails++; $display("FAIL reset detectdone: got %b expected 0", detectdone); end
    checks++; if (maxbin !== 10'd0) begin fails++; $display("FAIL reset maxbin: got %0d expected 0", maxbin); end
    checks++; if (maxmag !== 19'd0) begin fails++; $display("FAIL reset maxmag: got %0d expected 0", maxmag); end
    checks++; if (found !== 1'b0) begin fails++; $display("FAIL reset found: got %b expected 0", found); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single_peak();
    clear_mem();
    set_all(37, 1000, -500);
    start(0, 1023, 100);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL peak busy: got %b expected 1", busy); end
    wait_done(1030);
    checks++; if (lat !== 1026) begin fails++; $display("FAIL peak latency: got %0d expected 1026", lat); end
    checks++; if (pulses !== 1) begin fails++; $display("FAIL peak pulses: got %0d expected 1", pulses); end
    checks++; if (maxbin !== 10'd37) begin fails++; $display("FAIL peak maxbin: got %0d expected 37", maxbin); end
    checks++; if (maxmag !== 19'd6000) begin fails++; $display("FAIL peak maxmag: got %0d expected 6000", maxmag); end
    checks++; if (found !== 1'b1) begin fails++; $display("FAIL peak found: got %b expected 1", found); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL peak idle busy: got %b expected 0", busy); end
    checks++; if (ramaddr !== 10'd1023) begin fails++; $display("FAIL peak ramaddr hold: got %0d expected 1023", ramaddr); end
  endtask

  task automatic test_one_bin();
    start(37, 37, 0);
    wait_done(6);
    checks++; if (lat !== 3) begin fails++; $display("FAIL onebin latency: got %0d expected 3", lat); end
    checks++; if (maxbin !== 10'd37) begin fails++; $display("FAIL onebin maxbin: got %0d expected 37", maxbin); end
    checks++; if (maxmag !== 19'd6000) begin fails++; $display("FAIL onebin maxmag: got %0d expected 6000", maxmag); end
  endtask

  task automatic test_first_zero();
    start(300, 310, 0);
    wait_done(16);
    checks++; if (lat !== 13) begin fails++; $display("FAIL zero latency: got %0d expected 13", lat); end
    checks++; if (maxbin !== 10'd300) begin fails++; $display("FAIL zero maxbin: got %0d expected 300", maxbin); end
    checks++; if (maxmag !== 19'd0) begin fails++; $display("FAIL zero maxmag: got %0d expected 0", maxmag); end
    checks++; if (found !== 1'b1) begin fails++; $display("FAIL zero found: got %b expected 1", found); end
  endtask

  task automatic test_tie();
    clear_mem();
    set_ch(150, 2, 9, 0);
    set_ch(200, 0, 7, 3);
    set_ch(300, 1, -7, -3);
    set_ch(401, 0, 100, 0);
    start(100, 400, 10);
    wait_done(307);
    checks++; if (lat !== 303) begin fails++; $display("FAIL tie latency: got %0d expected 303", lat); end
    checks++; if (pulses !== 1) begin fails++; $display("FAIL tie pulses: got %0d expected 1", pulses); end
    checks++; if (maxbin !== 10'd200) begin fails++; $display("FAIL tie maxbin: got %0d expected 200", maxbin); end
    checks++; if (maxmag !== 19'd10) begin fails++; $display("FAIL tie maxmag: got %0d expected 10", maxmag); end
    checks++; if (found !== 1'b1) begin fails++; $display("FAIL tie found: got %b expected 1", found); end
  endtask

  task automatic test_window();
    clear_mem();
    set_all(50, 5000, 0);
    for (int b = 100; b <= 199; b++) set_all(b, 5, -5);
    set_all(200, 3000, 0);
    start(100, 199, 64);
    wait_done(106);
    checks++; if (lat !== 102) begin fails++; $display("FAIL window latency: got %0d expected 102", lat); end
    checks++; if (maxbin !== 10'd100) begin fails++; $display("FAIL window maxbin: got %0d expected 100", maxbin); end
    checks++; if (maxmag !== 19'd40) begin fails++; $display("FAIL window maxmag: got %0d expected 40", maxmag); end
    checks++; if (found !== 1'b0) begin fails++; $display("FAIL window found: got %b expected 0", found); end
  endtask

  task automatic test_empty();
    start(10, 5, 0);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL empty busy: got %b expected 1", busy); end
    checks++; if (ramaddr !== 10'd199) begin fails++; $display("FAIL empty ramaddr start: got %0d expected 199", ramaddr); end
    wait_done(6);
    checks++; if (lat !== 1) begin fails++; $display("FAIL empty latency: got %0d expected 1", lat); end
    checks++; if (pulses !== 1) begin fails++; $display("FAIL empty pulses: got %0d expected 1", pulses); end
    checks++; if (ramaddr !== 10'd199) begin fails++; $display("FAIL empty ramaddr end: got %0d expected 199", ramaddr); end
    checks++; if (maxbin !== 10'd10) begin fails++; $display("FAIL empty maxbin: got %0d expected 10", maxbin); end
    checks++; if (maxmag !== 19'd0) begin fails++; $display("FAIL empty maxmag: got %0d expected 0", maxmag); end
    checks++; if (found !== 1'b0) begin fails++; $display("FAIL empty found: got %b expected 0", found); end
  endtask

  task automatic test_min_neg();
    clear_mem();
    set_all(3, 32767, 32767);
    set_all(5, -32768, -32768);
    start(0, 9, 262144);
    wait_done(15);
    checks++; if (lat !== 12) begin fails++; $display("FAIL minneg latency: got %0d expected 12", lat); end
    checks++; if (maxbin !== 10'd5) begin fails++; $display("FAIL minneg maxbin: got %0d expected 5", maxbin); end
    checks++; if (maxmag !== 19'd262144) begin fails++; $display("FAIL minneg maxmag: got %0d expected 262144", maxmag); end
    checks++; if (found !== 1'b1) begin fails++; $display("FAIL minneg found: got %b expected 1", found); end
  endtask

  task automatic test_back_to_back();
    int busy_at_20;
    busy_at_20 = 0;
    start(0, 99, 0);
    lat = -1;
    pulses = 0;
    for (int k = 1; k <= 115; k++) begin
      @(negedge clk);
      if (detectdone === 1'b1) begin
        pulses++;
        if (lat < 0) lat = k;
      end
      if (k == 20) begin
        busy_at_20 = int'(busy);
        bin_lo = 10'd3;
        bin_hi = 10'd3;
        fftdone = 1'b1;
      end
      if (k == 21) fftdone = 1'b0;
    end
    checks++; if (busy_at_20 !== 1) begin fails++; $display("FAIL b2b busy: got %0d expected 1", busy_at_20); end
    checks++; if (lat !== 102) begin fails++; $display("FAIL b2b latency: got %0d expected 102", lat); end
    checks++; if (pulses !== 1) begin fails++; $display("FAIL b2b pulses: got %0d expected 1", pulses); end
    checks++; if (maxbin !== 10'd5) begin fails++; $display("FAIL b2b maxbin: got %0d expected 5", maxbin); end
    checks++; if (maxmag !== 19'd262144) begin fails++; $display("FAIL b2b maxmag: got %0d expected 262144", maxmag); end
  endtask

  task automatic test_reset_mid_scan();
    int busy_seen;
    busy_seen = 0;
    start(0, 99, 0);
    repeat (20) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (ramaddr !== 10'd0) begin fails++; $display("FAIL midrst ramaddr: got %0d expected 0", ramaddr); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst busy: got %b expected 0", busy); end
    checks++; if (maxbin !== 10'd0) begin fails++; $display("FAIL midrst maxbin: got %0d expected 0", maxbin); end
    checks++; if (maxmag !== 19'd0) begin fails++; $display("FAIL midrst maxmag: got %0d expected 0", maxmag); end
    checks++; if (found !== 1'b0) begin fails++; $display("FAIL midrst found: got %b expected 0", found); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      if (detectdone === 1'b1) pulses++;
      if (busy === 1'b1) busy_seen++;
    end
    checks++; if (pulses !== 0) begin fails++; $display("FAIL midrst pulses: got %0d expected 0", pulses); end
    checks++; if (busy_seen !== 0) begin fails++; $display("FAIL midrst busy cycles: got %0d expected 0", busy_seen); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    bin_lo = 10'd5;
    bin_hi = 10'd5;
    thresh = '0;
    fftdone = 1'b1;
    @(negedge clk);
    fftdone = 1'b0;
    wait_done(6);
    checks++; if (lat !== 3) begin fails++; $display("FAIL postrst latency: got %0d expected 3", lat); end
    checks++; if (maxbin !== 10'd5) begin fails++; $display("FAIL postrst maxbin: got %0d expected 5", maxbin); end
    checks++; if (maxmag !== 19'd262144) begin fails++; $display("FAIL postrst maxmag: got %0d expected 262144", maxmag); end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_single_peak();
    test_one_bin();
    test_first_zero();
    test_tie();
    test_window();
    test_empty();
    test_min_neg();
    test_back_to_back();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
